// File: rtl/reg_port_arbiter.sv
// rtl/reg_port_arbiter.sv - round-robin sequencer sharing the register-file side port
// Optional range check: define REG_ARB_RANGE_CHECK_EN.
module reg_port_arbiter #(
    parameter int NUM_REQ             = 4,
    parameter int DATA_WIDTH          = 32,
    parameter int NUMBER_OF_REGISTERS = 6
) (
    input  logic                          S_AXI_ACLK,
    input  logic                          S_AXI_ARESETN,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*8-1:0]          req_number,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            grant,
    output logic [NUM_REQ-1:0]            done,
    output logic [NUM_REQ-1:0]            err,
    output logic [DATA_WIDTH-1:0]         rdata,
    output logic                          busy,
    output logic [1:0]                    register_operation,
    output logic [7:0]                    register_number,
    output logic [DATA_WIDTH-1:0]         register_write,
    input  logic [DATA_WIDTH-1:0]         register_read
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ISSUE    = 3'd1,
        S_CAPTURE  = 3'd2,
`ifdef REG_ARB_RANGE_CHECK_EN
        S_COMPLETE = 3'd3,
        S_REJECT   = 3'd4
`else
        S_COMPLETE = 3'd3
`endif
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [IDX_W-1:0]        last_grant;
    logic                    lat_write;

    logic                    found;
    logic [IDX_W-1:0]        cand;
    logic [IDX_W-1:0]        sel_idx;
    logic [NUM_REQ-1:0]      sel_onehot;
    logic                    sel_write;
    logic [7:0]              sel_num;
    logic [DATA_WIDTH-1:0]   sel_wdata;
    logic                    sel_bad;

    // Search upward from the slot after the last owner, wrapping.
    always_comb begin
        found      = 1'b0;
        cand       = '0;
        sel_idx    = '0;
        sel_onehot = '0;
        sel_write  = 1'b0;
        sel_num    = '0;
        sel_wdata  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(last_grant) + k) % NUM_REQ);
            if (!found && req[cand]) begin
                found   = 1'b1;
                sel_idx = cand;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (sel_idx == IDX_W'(i)) begin
                sel_onehot[i] = 1'b1;
                sel_write     = req_write[i];
                sel_num       = req_number[8*i +: 8];
                sel_wdata     = req_wdata[DATA_WIDTH*i +: DATA_WIDTH];
            end
        end
`ifdef REG_ARB_RANGE_CHECK_EN
        sel_bad = (sel_num >= 8'(NUMBER_OF_REGISTERS));
`else
        sel_bad = 1'b0;
`endif
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (found) begin
`ifdef REG_ARB_RANGE_CHECK_EN
                    state_next = sel_bad ? S_REJECT : S_ISSUE;
`else
                    state_next = S_ISSUE;
`endif
                end
            end
            S_ISSUE:    state_next = S_CAPTURE;
            S_CAPTURE:  state_next = S_COMPLETE;
            S_COMPLETE: state_next = S_IDLE;
`ifdef REG_ARB_RANGE_CHECK_EN
            S_REJECT:   state_next = S_IDLE;
`endif
            default:    state_next = S_IDLE;
        endcase
    end

    // Outputs are registered on the edge that enters each state.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            grant              <= '0;
            done               <= '0;
            rdata              <= '0;
            busy               <= 1'b0;
            register_operation <= 2'd0;
            register_number    <= '0;
            register_write     <= '0;
            last_grant         <= IDX_W'(NUM_REQ - 1);
            lat_write          <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done               <= '0;
                    register_operation <= 2'd0;
                    if (found) begin
                        grant           <= sel_onehot;
                        busy            <= 1'b1;
                        last_grant      <= sel_idx;
                        lat_write       <= sel_write;
                        register_number <= sel_num;
                        register_write  <= sel_wdata;
                        if (sel_bad) begin
                            done <= sel_onehot;
                        end else begin
                            register_operation <= sel_write ? 2'd2 : 2'd1;
                        end
                    end
                end
                S_ISSUE: begin
                    register_operation <= 2'd0;
                end
                S_CAPTURE: begin
                    if (!lat_write) begin
                        rdata <= register_read;
                    end
                    register_operation <= 2'd3;
                    done               <= grant;
                end
                default: begin
                    register_operation <= 2'd0;
                    done               <= '0;
                    grant              <= '0;
                    busy               <= 1'b0;
                end
            endcase
        end
    end

`ifdef REG_ARB_RANGE_CHECK_EN
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            err <= '0;
        end else if (state == S_IDLE && found && sel_bad) begin
            err <= sel_onehot;
        end else begin
            err <= '0;
        end
    end
`else
    assign err = '0;
`endif

endmodule

// File: tb/tb_reg_port_arbiter.sv
// tb/tb_reg_port_arbiter.sv - directed self-checking bench for reg_port_arbiter
module tb_reg_port_arbiter;

    logic         clk;
    logic         rst_n;
    logic [3:0]   req;
    logic [3:0]   req_write;
    logic [31:0]  req_number;
    logic [127:0] req_wdata;
    logic [3:0]   grant;
    logic [3:0]   done;
    logic [3:0]   err;
    logic [31:0]  rdata;
    logic         busy;
    logic [1:0]   register_operation;
    logic [7:0]   register_number;
    logic [31:0]  register_write;
    logic [31:0]  register_read;

    logic [31:0]  regs [0:255];
    int           total;
    int           bad;

    reg_port_arbiter #(.NUM_REQ(4), .DATA_WIDTH(32), .NUMBER_OF_REGISTERS(6)) dut (
        .S_AXI_ACLK         (clk),
        .S_AXI_ARESETN      (rst_n),
        .req                (req),
        .req_write          (req_write),
        .req_number         (req_number),
        .req_wdata          (req_wdata),
        .grant              (grant),
        .done               (done),
        .err                (err),
        .rdata              (rdata),
        .busy               (busy),
        .register_operation (register_operation),
        .register_number    (register_number),
        .register_write     (register_write),
        .register_read      (register_read)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file on the far side of the port: read data lands one cycle after a read op.
    always @(posedge clk) begin
        if (register_operation == 2'd2) regs[register_number] <= register_write;
        if (register_operation == 2'd1) register_read <= regs[register_number];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_fields(input int i, input logic wr, input logic [7:0] num, input logic [31:0] d);
        req_write[i]        = wr;
        req_number[8*i +: 8] = num;
        req_wdata[32*i +: 32] = d;
    endtask

    logic [3:0] alt_order [4];

    initial begin
        total      = 0;
        bad        = 0;
        rst_n      = 1'b0;
        req        = '0;
        req_write  = '0;
        req_number = '0;
        req_wdata  = '0;
        alt_order  = '{4'b0010, 4'b1000, 4'b0010, 4'b1000};
        repeat (2) @(negedge clk);
        check("rst_grant", grant, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_rdata", rdata, 0);
        check("rst_busy", busy, 0);
        check("rst_op", register_operation, 0);
        check("rst_num", register_number, 0);
        check("rst_wr", register_write, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // requester 0 writes DEADBEEF to register 2
        set_fields(0, 1'b1, 8'd2, 32'hDEADBEEF);
        req[0] = 1'b1;
        @(negedge clk);
        check("t1_op_issue", register_operation, 2);
        check("t1_num", register_number, 2);
        check("t1_wdata", register_write, 32'hDEADBEEF);
        check("t1_grant", grant, 4'b0001);
        check("t1_busy", busy, 1);
        check("t1_done_early", done, 0);
        @(negedge clk);
        check("t1_op_capture", register_operation, 0);
        check("t1_done_capture", done, 0);
        @(negedge clk);
        check("t1_op_complete", register_operation, 3);
        check("t1_done", done, 4'b0001);
        req[0] = 1'b0;
        @(negedge clk);
        check("t1_op_idle", register_operation, 0);
        check("t1_busy_idle", busy, 0);
        check("t1_grant_idle", grant, 0);
        check("t1_done_idle", done, 0);

        // requester 1 reads register 2 back
        set_fields(1, 1'b0, 8'd2, 32'h0);
        req[1] = 1'b1;
        @(negedge clk);
        check("t2_op_issue", register_operation, 1);
        check("t2_num", register_number, 2);
        check("t2_grant", grant, 4'b0010);
        @(negedge clk);
        check("t2_op_capture", register_operation, 0);
        @(negedge clk);
        check("t2_op_complete", register_operation, 3);
        check("t2_done", done, 4'b0010);
        check("t2_rdata", rdata, 32'hDEADBEEF);
        req[1] = 1'b0;
        @(negedge clk);

        // fresh reset, then all four request together
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) set_fields(i, 1'b0, 8'(i), 32'h0);
        req = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("t3_grant%0d", k), grant, 32'(4'b0001 << k));
            check($sformatf("t3_busy%0d", k), busy, 1);
            @(negedge clk);
            @(negedge clk);
            check($sformatf("t3_done%0d", k), done, 32'(4'b0001 << k));
            if (k == 2) check("t3_rdata2", rdata, 32'hDEADBEEF);
            req[k] = 1'b0;
            @(negedge clk);
            check($sformatf("t3_gap%0d", k), busy, 0);
        end

        // requesters 1 and 3 hold req continuously
        set_fields(1, 1'b1, 8'd4, 32'h1111);
        set_fields(3, 1'b1, 8'd5, 32'h3333);
        req = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("t4_grant%0d", k), grant, 32'(alt_order[k]));
            @(negedge clk);
            @(negedge clk);
            check($sformatf("t4_done%0d", k), done, 32'(alt_order[k]));
            @(negedge clk);
            check($sformatf("t4_gap%0d", k), busy, 0);
        end
        req = '0;
        @(negedge clk);
        check("t4_quiet", grant, 0);

        // requester 2 reads out-of-range register 7
        set_fields(2, 1'b0, 8'd7, 32'h0);
        req[2] = 1'b1;
        @(negedge clk);
`ifdef REG_ARB_RANGE_CHECK_EN
        check("t5_err", err, 4'b0100);
        check("t5_done", done, 4'b0100);
        check("t5_op", register_operation, 0);
        req[2] = 1'b0;
        @(negedge clk);
        check("t5_err_clear", err, 0);
        check("t5_busy_clear", busy, 0);
`else
        check("t5_op", register_operation, 1);
        check("t5_num", register_number, 7);
        check("t5_err", err, 0);
        @(negedge clk);
        @(negedge clk);
        check("t5_done", done, 4'b0100);
        req[2] = 1'b0;
        @(negedge clk);
`endif

        // reset pulse during CAPTURE abandons the transaction
        set_fields(0, 1'b1, 8'd3, 32'h12345678);
        req[0] = 1'b1;
        @(negedge clk);
        check("t6_grant", grant, 4'b0001);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t6_rst_grant", grant, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_op", register_operation, 0);
        req = '0;
        @(negedge clk);
        check("t6_no_done", done, 0);
        rst_n = 1'b1;
        set_fields(0, 1'b0, 8'd3, 32'h0);
        set_fields(3, 1'b0, 8'd2, 32'h0);
        req = 4'b1001;
        @(negedge clk);
        check("t6_regrant", grant, 4'b0001);
        check("t6_op", register_operation, 1);
        check("t6_num", register_number, 3);
        @(negedge clk);
        @(negedge clk);
        check("t6_done", done, 4'b0001);
        req = '0;
        @(negedge clk);
        check("t6_idle", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
